instr_encoder: RTL



---
 rtl/instr_encoder_pkg.sv | 44 ++++
 rtl/instr_encoder_imm_packer.sv | 65 ++++++
 rtl/instr_encoder.sv | 122 ++++++++++++
 3 files changed

// File: rtl/instr_encoder_pkg.sv
// -----------------------------------------------------------------------------
// instr_encoder_pkg
// Constants shared by the RV32I instruction decoder and encoder: the opcodes
// this codebase handles, the 3-bit immediate-format codes and the canonical
// NOP (addi x0,x0,0). fmt_from_op maps an opcode onto its immediate format.
// -----------------------------------------------------------------------------
package instr_encoder_pkg;

   localparam logic [6:0] LW    = 7'b0000011;
   localparam logic [6:0] ITP   = 7'b0010011;
   localparam logic [6:0] SW    = 7'b0100011;
   localparam logic [6:0] BEQ   = 7'b1100011;
   localparam logic [6:0] JAL   = 7'b1101111;
   localparam logic [6:0] LUI   = 7'b0110111;
   localparam logic [6:0] RTYPE = 7'b0110011;

   // ImmR marks R-type (no immediate); ImmX marks an opcode we cannot encode.
   typedef enum logic [2:0] {
      ImmI = 3'd0,
      ImmS = 3'd1,
      ImmB = 3'd2,
      ImmJ = 3'd3,
      ImmU = 3'd4,
      ImmR = 3'd5,
      ImmX = 3'd7
   } imm_fmt_e;

   localparam logic [31:0] NOP = 32'h0000_0013;

   function automatic imm_fmt_e fmt_from_op(input logic [6:0] op);
      imm_fmt_e f;
      case (op)
         RTYPE:   f = ImmR;
         LW, ITP: f = ImmI;
         SW:      f = ImmS;
         BEQ:     f = ImmB;
         JAL:     f = ImmJ;
         LUI:     f = ImmU;
         default: f = ImmX;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/instr_encoder_imm_packer.sv
// -----------------------------------------------------------------------------
// instr_encoder_imm_packer
// Combinational packer: scatters the register/funct fields and the immediate
// into the RV32I layout of the given format and range-checks the immediate.
// Anything that cannot be encoded yields NOP with illegal raised.
//   fmt      : immediate format (from fmt_from_op)
//   op/rd/rs1/rs2/funct3/funct7 : instruction fields
//   imm      : signed immediate (byte offset for B/J, full value for U)
//   word     : packed instruction (NOP when illegal)
//   illegal  : opcode or immediate not encodable
// -----------------------------------------------------------------------------
module instr_encoder_imm_packer
   import instr_encoder_pkg::*;
(
   input  imm_fmt_e           fmt,
   input  logic [6:0]         op,
   input  logic [4:0]         rd,
   input  logic [4:0]         rs1,
   input  logic [4:0]         rs2,
   input  logic [2:0]         funct3,
   input  logic [6:0]         funct7,
   input  logic signed [31:0] imm,
   output logic [31:0]        word,
   output logic               illegal
);

   function automatic logic in_range(input logic signed [31:0] v,
                                     input logic signed [31:0] lo,
                                     input logic signed [31:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

   always_comb begin
      word    = NOP;
      illegal = 1'b0;
      case (fmt)
         ImmR: word = {funct7, rs2, rs1, funct3, rd, op};
         ImmI: begin
            illegal = !in_range(imm, -32'sd2048, 32'sd2047);
            word    = {imm[11:0], rs1, funct3, rd, op};
         end
         ImmS: begin
            illegal = !in_range(imm, -32'sd2048, 32'sd2047);
            word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
         end
         // Branch and jump offsets are half-word aligned; bit 0 is not stored.
         ImmB: begin
            illegal = !in_range(imm, -32'sd4096, 32'sd4094) || imm[0];
            word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
         end
         ImmJ: begin
            illegal = !in_range(imm, -32'sd1048576, 32'sd1048574) || imm[0];
            word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
         end
         // LUI carries the full value; low 12 bits must already be zero.
         ImmU: begin
            illegal = (imm[11:0] != 12'd0);
            word    = {imm[31:12], rd, op};
         end
         default: illegal = 1'b1;
      endcase
      if (illegal) word = NOP;
   end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Streaming RV32I encoder. A start/len run accepts len field bundles, encodes
// each and emits it with a sequential word address through a single output
// register (valid/ready, full throughput).
//   clk, rst          : clock, synchronous active-high reset
//   start/len/base_addr : run control, honoured only while idle
//   in_valid/in_ready : field bundle handshake (in_op..in_imm)
//   out_valid/out_ready : encoded word handshake (out_instr, out_addr)
//   busy              : run in progress
//   done              : one-cycle pulse at the end of a run
//   err               : sticky illegal-encode flag, cleared by a start
// -----------------------------------------------------------------------------
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int LEN_W  = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [6:0]        in_op,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [31:0]       in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

   state_e            state;
   logic [ADDR_W-1:0] addr_cnt;
   logic [LEN_W-1:0]  remaining;
   imm_fmt_e          fmt;
   logic [31:0]       enc_word;
   logic              enc_illegal;
   logic              accept;

   assign fmt = fmt_from_op(in_op);

   instr_encoder_imm_packer u_imm_packer (
      .fmt     (fmt),
      .op      (in_op),
      .rd      (in_rd),
      .rs1     (in_rs1),
      .rs2     (in_rs2),
      .funct3  (in_funct3),
      .funct7  (in_funct7),
      .imm     ($signed(in_imm)),
      .word    (enc_word),
      .illegal (enc_illegal)
   );

   // Output register frees up in the same cycle it hands off.
   assign in_ready = (state == RUN) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         addr_cnt  <= '0;
         remaining <= '0;
         out_valid <= 1'b0;
         out_instr <= '0;
         out_addr  <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  err <= 1'b0;
                  if (len != '0) begin
                     state     <= RUN;
                     addr_cnt  <= base_addr;
                     remaining <= len;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (out_valid && out_ready) out_valid <= 1'b0;
               if (accept) begin
                  out_valid <= 1'b1;
                  out_instr <= enc_word;
                  out_addr  <= addr_cnt;
                  addr_cnt  <= addr_cnt + ADDR_W'(1);
                  remaining <= remaining - LEN_W'(1);
                  if (enc_illegal) err <= 1'b1;
                  if (remaining == LEN_W'(1)) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (!out_valid || out_ready) begin
                  out_valid <= 1'b0;
                  done      <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
